// File: rtl/avr_pkg.sv
// avr_pkg: ATmega328p data-space map, widths and responder state encoding.
package avr_pkg;
    localparam int          ADDR_W     = 16;
    localparam int          DATA_W     = 8;
    localparam logic [15:0] IO_BASE    = 16'h0020;
    localparam logic [15:0] SRAM_BASE  = 16'h0100;
    localparam logic [15:0] SRAM_END   = 16'h08FF;
    localparam int          SRAM_DEPTH = int'(SRAM_END - SRAM_BASE) + 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} rsp_state_e;
endpackage

// File: rtl/sram_1p.sv
// sram_1p: single-port synchronous RAM with write enable and registered read.
module sram_1p #(
    parameter int DATA_W = avr_pkg::DATA_W,
    parameter int DEPTH  = avr_pkg::SRAM_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) r_mem[i_addr] <= i_wdata;
            r_q <= r_mem[i_addr];
        end
    end
    assign o_rdata = r_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: far end of the CU load/store bus; decodes the AVR data map
// into I/O strobes, local SRAM or an error response with configurable wait states.
module dmem_responder #(
    parameter int                ADDR_W      = avr_pkg::ADDR_W,
    parameter int                DATA_W      = avr_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] SRAM_BASE   = avr_pkg::SRAM_BASE,
    parameter int                SRAM_DEPTH  = avr_pkg::SRAM_DEPTH,
    parameter logic [ADDR_W-1:0] IO_BASE     = avr_pkg::IO_BASE,
    parameter int                WAIT_STATES = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ,
    input  logic              WE,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic              ACK,
    output logic [DATA_W-1:0] RDATA,
    output logic              ERR,
    output logic              BUSY,
    output logic              IO_STB,
    output logic              IO_WE,
    output logic [7:0]        IO_ADDR,
    output logic [DATA_W-1:0] IO_WDATA,
    input  logic [DATA_W-1:0] IO_RDATA
);
    import avr_pkg::*;

    localparam int                RAM_AW    = $clog2(SRAM_DEPTH);
    localparam logic [ADDR_W-1:0] SRAM_LAST = ADDR_W'(SRAM_BASE + SRAM_DEPTH - 1);

    rsp_state_e        r_state, w_next;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    logic              w_in_sram;
    logic              w_in_io;
    logic              w_acc;
    logic              w_accept;
    logic [DATA_W-1:0] w_ram_q;

    assign w_in_sram = r_addr >= SRAM_BASE && r_addr <= SRAM_LAST;
    assign w_in_io   = r_addr >= IO_BASE && r_addr < SRAM_BASE;
    assign w_acc     = r_state == S_ACCESS;
    assign w_accept  = r_state == S_IDLE && REQ;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (REQ) w_next = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            S_WAIT:   if (r_cnt <= 4'd1) w_next = S_ACCESS;
            S_ACCESS: w_next = S_RESP;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= ADDR;
                r_we    <= WE;
                r_wdata <= WDATA;
                r_cnt   <= 4'(WAIT_STATES);
                r_err   <= 1'b0;
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_acc) begin
                r_err   <= !w_in_sram && !w_in_io;
                r_rdata <= (w_in_io && !r_we) ? IO_RDATA : '0;
            end
        end
    end

    sram_1p #(.DATA_W(DATA_W), .DEPTH(SRAM_DEPTH)) u_sram (
        .i_clk   (CLK),
        .i_en    (w_acc && w_in_sram),
        .i_we    (r_we),
        .i_addr  (RAM_AW'(r_addr - SRAM_BASE)),
        .i_wdata (r_wdata),
        .o_rdata (w_ram_q)
    );

    // SRAM load data arrives from the RAM's read register during RESP
    assign ACK      = r_state == S_RESP;
    assign BUSY     = r_state != S_IDLE;
    assign ERR      = r_err;
    assign RDATA    = (ACK && w_in_sram && !r_we) ? w_ram_q : r_rdata;
    assign IO_STB   = w_acc && w_in_io;
    assign IO_WE    = IO_STB && r_we;
    assign IO_ADDR  = IO_STB ? 8'(r_addr - IO_BASE) : '0;
    assign IO_WDATA = IO_STB ? r_wdata : '0;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-space responder serving the CU's load/store bus for the ATmega328p core. The CU is the initiator; this block is the far end of that bus.
- Decodes the 16-bit data address into the AVR data map:
  - I/O window 0x0020–0x00FF, forwarded to peripherals.
  - Internal SRAM 0x0100–0x08FF, held in a local array.
  - Everything else is an error.
- Single outstanding transaction, req/ack handshake, configurable wait states.

Parameters:
- ADDR_W, 16, data-space address width
- DATA_W, 8, data width
- SRAM_BASE, 16'h0100, first SRAM address
- SRAM_DEPTH, 2048, SRAM bytes; last address = SRAM_BASE+SRAM_DEPTH-1 (0x08FF)
- IO_BASE, 16'h0020, first I/O address; I/O window ends at SRAM_BASE-1
- WAIT_STATES, 1, extra cycles inserted before the access cycle (0..15)

Ports:
- CLK  in  1  core clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- REQ  in  1  CU request; ADDR/WE/WDATA sampled in IDLE when REQ=1
- WE  in  1  1=store, 0=load
- ADDR  in  ADDR_W  data-space address
- WDATA  in  DATA_W  store data
- ACK  out  1  one-cycle completion pulse
- RDATA  out  DATA_W  load data, valid while ACK=1
- ERR  out  1  qualifies ACK: address outside I/O or SRAM windows
- BUSY  out  1  high in every state except IDLE
- IO_STB  out  1  one-cycle peripheral access strobe
- IO_WE  out  1  peripheral write enable, valid with IO_STB
- IO_ADDR  out  8  ADDR minus IO_BASE, valid with IO_STB
- IO_WDATA  out  DATA_W  peripheral write data, valid with IO_STB
- IO_RDATA  in  DATA_W  peripheral read data; sampled on the edge ending the IO_STB cycle

Behaviour:
- Reset (RST=0, async):
  - FSM goes to IDLE.
  - ACK, ERR, BUSY, IO_STB, IO_WE = 0; RDATA, IO_ADDR, IO_WDATA = 0.
  - Wait counter = 0.
  - SRAM contents are not cleared.
- FSM states: IDLE, WAIT, ACCESS, RESP.
  - IDLE: if REQ=1, latch ADDR/WE/WDATA, load wait counter with WAIT_STATES, and go to WAIT (or ACCESS if WAIT_STATES=0).
  - WAIT: decrement the counter each cycle; go to ACCESS when the counter reaches 1.
  - ACCESS: exactly one cycle; performs the access (see decode below); go to RESP.
  - RESP: ACK=1 for exactly one cycle; RDATA and ERR held valid; go to IDLE.
- Latency: ACK rises WAIT_STATES+2 cycles after the edge that samples REQ. With WAIT_STATES=1, REQ sampled at edge n gives ACK high in cycle n+3.
- Decode in ACCESS, on the latched address:
  - SRAM_BASE ≤ a ≤ last SRAM address:
    - Store: write the byte at index a-SRAM_BASE.
    - Load: RDATA register ← array[a-SRAM_BASE].
  - IO_BASE ≤ a < SRAM_BASE:
    - IO_STB=1, IO_WE=WE, IO_ADDR=a-IO_BASE (0x00..0xDF), IO_WDATA=latched data.
    - Load: RDATA ← IO_RDATA at the end of the cycle.
    - Store: RDATA ← 0.
  - a < IO_BASE (register-file mirror, owned by the CU) or a > 0x08FF: ERR ← 1, RDATA ← 0, no SRAM write, no IO_STB.
- ERR is cleared when the next transaction is accepted. ERR is only meaningful while ACK=1.
- Handshake rules:
  - The CU holds REQ and operands stable until ACK.
  - REQ deasserting after acceptance does not cancel the transaction; ACK is still issued.
  - REQ=1 in the IDLE cycle right after RESP is accepted as a new transaction (back-to-back allowed). Minimum spacing is WAIT_STATES+3 cycles between accepts.
  - REQ is ignored while BUSY=1.
- Store-then-load to the same SRAM address, back-to-back: the load returns the new value, since the store committed in an earlier ACCESS cycle.
- Reset mid-transaction:
  - Abort to IDLE; no ACK issued.
  - A store not yet in ACCESS is dropped.
  - A store whose ACCESS edge has already occurred is kept.

Decomposition:
- Shared package `avr_pkg` holds:
  - data-map constants IO_BASE, SRAM_BASE, SRAM_END;
  - the responder state enum;
  - the data width.
- One natural sub-module: `sram_1p`, a single-port synchronous RAM (DATA_W x SRAM_DEPTH) with write enable and registered read. The responder FSM, decode and I/O strobe logic stay in `dmem_responder`.

Test Plan:
- Reset hold: RST=0 for 3 cycles with REQ=1 → ACK=0, BUSY=0, IO_STB=0, RDATA=0x00 throughout. Release RST → first accept on the next edge.
- SRAM round trip (WAIT_STATES=1):
  - Store 0xA5 to 0x0100, then load 0x0100 → ACK 3 cycles after each accept, load RDATA=0xA5, ERR=0.
  - Repeat at 0x08FF with 0x3C → RDATA=0x3C.
- I/O access:
  - Store 0x55 to 0x0025 → exactly one IO_STB cycle with IO_WE=1, IO_ADDR=0x05, IO_WDATA=0x55.
  - Load 0x005F with IO_RDATA driven to 0x81 → IO_ADDR=0x3F, RDATA=0x81 on ACK.
- Error windows:
  - Load 0x001F, store 0x0900, load 0xFFFF → each gives ACK with ERR=1, RDATA=0x00, no IO_STB.
  - A following load of 0x0100 shows the SRAM byte unchanged.
- Back-to-back with WAIT_STATES=0:
  - REQ held high across 3 loads → ACK every 3 cycles, BUSY low exactly one cycle between transactions.
  - REQ dropped one cycle after accept → ACK still issued.
- Reset mid-operation: store 0x77 to 0x0200, assert RST during WAIT → no ACK; after release, load 0x0200 returns the previous contents (pre-loaded 0x11), not 0x77.
